// File: rtl/key_conditioner.sv
// key_conditioner: synchronizes and debounces three active-low pushbuttons,
// then adds a fire-key press pulse with auto-repeat and a sticky request flag.
module key_conditioner #(
  parameter int DEBOUNCE      = 500000,
  parameter int CNT_W         = 20,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter int RPT_W         = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic key_right_raw,
  input  logic key_left_raw,
  input  logic key_fire_raw,
  input  logic tik,
  output logic key_right,
  output logic key_left,
  output logic key_fire,
  output logic fire_press,
  output logic fire_req
);

  localparam logic [CNT_W-1:0] DB_MAX  = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [RPT_W-1:0] RD_LOAD = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RP_LOAD = RPT_W'(REPEAT_PERIOD - 1);
  localparam logic [RPT_W-1:0] RPT_ONE = RPT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } state_t;

  logic [2:0]       raw;
  logic [2:0]       sync0;
  logic [2:0]       sync1;
  logic [2:0]       stable;
  logic [CNT_W-1:0] cnt [3];
  logic             fire_fall;

  state_t           state_q;
  state_t           state_d;
  logic [RPT_W-1:0] rcnt_q;
  logic [RPT_W-1:0] rcnt_d;
  logic             press_d;

  // bit 0 right, bit 1 left, bit 2 fire
  assign raw = {key_fire_raw, key_left_raw, key_right_raw};

  // Two-flop synchronizer; released level is 1
  always_ff @(posedge clk) begin
    if (rst) begin
      sync0 <= '1;
      sync1 <= '1;
    end else begin
      sync0 <= raw;
      sync1 <= sync0;
    end
  end

  // Per-key debounce: level flips after DEBOUNCE consecutive differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      stable <= '1;
      for (int k = 0; k < 3; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (sync1[k] == stable[k]) begin
          cnt[k] <= '0;
        end else if (cnt[k] == DB_MAX) begin
          stable[k] <= sync1[k];
          cnt[k]    <= '0;
        end else begin
          cnt[k] <= cnt[k] + CNT_ONE;
        end
      end
    end
  end

  assign key_right = stable[0];
  assign key_left  = stable[1];
  assign key_fire  = stable[2];

  // Fire level is about to fall on this edge: lets the pulse align with it
  assign fire_fall = stable[2] & ~sync1[2] & (cnt[2] == DB_MAX);

  // Auto-repeat next state, counter and pulse
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    press_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fire_fall) begin
          press_d = 1'b1;
          rcnt_d  = RD_LOAD;
          state_d = DELAY;
        end
      end
      DELAY, REPEAT: begin
        if (stable[2]) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else if (rcnt_q == '0) begin
          press_d = 1'b1;
          rcnt_d  = RP_LOAD;
          state_d = REPEAT;
        end else begin
          rcnt_d = rcnt_q - RPT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        rcnt_d  = '0;
      end
    endcase
  end

  // Auto-repeat registers and sticky request; a new pulse wins over tik
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rcnt_q     <= '0;
      fire_press <= 1'b0;
      fire_req   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rcnt_q     <= rcnt_d;
      fire_press <= press_d;
      fire_req   <= fire_press | (fire_req & ~tik);
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed scenarios with literal expectations plus
// randomized stimulus compared every cycle against a behavioural model.
module tb_key_conditioner;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_right_raw = 1'b1;
  logic key_left_raw  = 1'b1;
  logic key_fire_raw  = 1'b1;
  logic tik = 1'b0;
  logic key_right;
  logic key_left;
  logic key_fire;
  logic fire_press;
  logic fire_req;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  key_conditioner #(
    .DEBOUNCE(DB),
    .CNT_W(4),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP),
    .RPT_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_right_raw(key_right_raw),
    .key_left_raw(key_left_raw),
    .key_fire_raw(key_fire_raw),
    .tik(tik),
    .key_right(key_right),
    .key_left(key_left),
    .key_fire(key_fire),
    .fire_press(fire_press),
    .fire_req(fire_req)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: delay line, sample windows and elapsed hold time
  bit m_s0 [3] = '{1'b1, 1'b1, 1'b1};
  bit m_s1 [3] = '{1'b1, 1'b1, 1'b1};
  bit m_st [3] = '{1'b1, 1'b1, 1'b1};
  bit hist [3][$];
  bit m_press = 1'b0;
  bit m_req = 1'b0;
  int cyc = 0;
  int fall_cyc = 0;

  always @(posedge clk) begin
    bit raw [3];
    bit old_kf;
    bit flip;
    bit npress;
    int e;
    raw = '{key_right_raw, key_left_raw, key_fire_raw};
    cyc++;
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        m_s0[k] = 1'b1;
        m_s1[k] = 1'b1;
        m_st[k] = 1'b1;
        hist[k].delete();
      end
      m_press = 1'b0;
      m_req = 1'b0;
    end else begin
      old_kf = m_st[2];
      for (int k = 0; k < 3; k++) begin
        hist[k].push_back(m_s1[k]);
        if (hist[k].size() > DB) void'(hist[k].pop_front());
        flip = (hist[k].size() == DB);
        foreach (hist[k][j]) if (hist[k][j] == m_st[k]) flip = 1'b0;
        m_s1[k] = m_s0[k];
        m_s0[k] = raw[k];
        if (flip) m_st[k] = ~m_st[k];
      end
      npress = 1'b0;
      if (old_kf && !m_st[2]) begin
        npress = 1'b1;
        fall_cyc = cyc;
      end else if (!old_kf) begin
        e = cyc - fall_cyc;
        if (e >= RD && (e - RD) % RP == 0) npress = 1'b1;
      end
      m_req = m_press | (m_req & !tik);
      m_press = npress;
    end
  end

  // Compare DUT against model on every falling edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("key_right", 32'(key_right), 32'(m_st[0]));
      chk("key_left", 32'(key_left), 32'(m_st[1]));
      chk("key_fire", 32'(key_fire), 32'(m_st[2]));
      chk("fire_press", 32'(fire_press), 32'(m_press));
      chk("fire_req", 32'(fire_req), 32'(m_req));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int pe [$];
  int exp_pe [5] = '{6, 16, 21, 26, 31};

  initial begin
    repeat (2) step();
    cmp_en = 1'b1;
    chk("rst_right", 32'(key_right), 32'd1);
    chk("rst_left", 32'(key_left), 32'd1);
    chk("rst_fire", 32'(key_fire), 32'd1);
    chk("rst_press", 32'(fire_press), 32'd0);
    chk("rst_req", 32'(fire_req), 32'd0);

    // left key press and release latency
    rst = 1'b0;
    key_left_raw = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i == 5) chk("left_fall_e5", 32'(key_left), 32'd1);
      if (i == 6) chk("left_fall_e6", 32'(key_left), 32'd0);
    end
    key_left_raw = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i == 5) chk("left_rise_e5", 32'(key_left), 32'd0);
      if (i == 6) chk("left_rise_e6", 32'(key_left), 32'd1);
    end

    // short glitches twice: second would fire if progress were kept
    pe.delete();
    for (int g = 0; g < 2; g++) begin
      key_fire_raw = 1'b0;
      repeat (3) begin
        step();
        if (fire_press) pe.push_back(1);
      end
      key_fire_raw = 1'b1;
      repeat (8) begin
        step();
        if (fire_press) pe.push_back(1);
      end
    end
    chk("glitch_fire", 32'(key_fire), 32'd1);
    chk("glitch_pulses", 32'(pe.size()), 32'd0);
    chk("glitch_req", 32'(fire_req), 32'd0);

    // held fire: press plus auto-repeat, released after edge 28
    pe.delete();
    key_fire_raw = 1'b0;
    for (int i = 1; i <= 45; i++) begin
      step();
      if (fire_press) pe.push_back(i);
      if (i == 7) chk("req_set", 32'(fire_req), 32'd1);
      if (i == 28) key_fire_raw = 1'b1;
    end
    chk("rep_count", 32'(pe.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < pe.size()) chk("rep_edge", 32'(pe[i]), 32'(exp_pe[i]));
    chk("rep_released", 32'(key_fire), 32'd1);
    chk("req_held", 32'(fire_req), 32'd1);
    tik = 1'b1;
    step();
    tik = 1'b0;
    chk("req_clear", 32'(fire_req), 32'd0);
    tik = 1'b1;
    step();
    tik = 1'b0;
    step();
    chk("req_idle_tik", 32'(fire_req), 32'd0);

    // tik coincident with the press pulse keeps the request
    key_fire_raw = 1'b0;
    repeat (6) step();
    chk("co_press", 32'(fire_press), 32'd1);
    tik = 1'b1;
    step();
    tik = 1'b0;
    chk("co_req", 32'(fire_req), 32'd1);

    // reset in REPEAT with key held: fresh press after release
    repeat (14) step();
    rst = 1'b1;
    step();
    chk("mid_rst_fire", 32'(key_fire), 32'd1);
    chk("mid_rst_press", 32'(fire_press), 32'd0);
    chk("mid_rst_req", 32'(fire_req), 32'd0);
    rst = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i == 5) chk("re_fire_e5", 32'(key_fire), 32'd1);
      if (i == 6) chk("re_fire_e6", 32'(key_fire), 32'd0);
      if (i == 6) chk("re_press_e6", 32'(fire_press), 32'd1);
    end
    key_fire_raw = 1'b1;

    // randomized phase
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 9) == 0) key_right_raw = ~key_right_raw;
      if ($urandom_range(0, 9) == 0) key_left_raw = ~key_left_raw;
      if ($urandom_range(0, 24) == 0) key_fire_raw = ~key_fire_raw;
      tik = ($urandom_range(0, 4) == 0);
      rst = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0;
    tik = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
